cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//   Sits directly downstream of the cache block. Arbitrates the icache and dcache
//   request ports onto the single-ported RAM bus, with one request in flight at a
//   time. Generates iwait/dwait back to the caches and steers ramload to the
//   granted requester. Dcache has priority; a starvation counter guarantees forward
//   progress for instruction fetch.
// PARAMETERS
//   WORD_W        32  data width of iload/dload/dstore/ramstore/ramload
//   ADDR_W        32  address width of iaddr/daddr/ramaddr
//   STARVE_LIMIT  4   consecutive dcache grants while iREN pending before icache is forced
// PORTS
//   CLK       in   1       clock, rising edge
//   nRST      in   1       synchronous reset, active-low
//   iREN      in   1       icache read request
//   iaddr     in   ADDR_W  icache address
//   iwait     out  1       0 = iload valid / icache request complete this cycle
//   iload     out  WORD_W  instruction word to icache
//   dREN      in   1       dcache read request
//   dWEN      in   1       dcache write request
//   daddr     in   ADDR_W  dcache address
//   dstore    in   WORD_W  dcache write data
//   dwait     out  1       0 = dcache request complete this cycle
//   dload     out  WORD_W  data word to dcache
//   ramREN    out  1       RAM read enable
//   ramWEN    out  1       RAM write enable
//   ramaddr   out  ADDR_W  RAM address
//   ramstore  out  WORD_W  RAM write data
//   ramload   in   WORD_W  RAM read data
//   ramstate  in   2       0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
// BEHAVIOUR
// - Reset (nRST=0 at posedge): state IDLE, grant cleared, starve_cnt=0.
//   Outputs while in IDLE: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1,
//   iload=dload=0.
// - FSM states: IDLE, ISERVE, DSERVE.
//   IDLE -> DSERVE if (dREN|dWEN) and not (iREN and starve_cnt==STARVE_LIMIT).
//   IDLE -> ISERVE if iREN and (no d request or starve_cnt==STARVE_LIMIT).
//   IDLE -> IDLE otherwise.
// - In DSERVE:
//   - ramaddr=daddr, ramstore=dstore.
//   - dREN&dWEN both high is treated as a write: ramWEN=1, ramREN=0.
//   - Otherwise ramREN=dREN, ramWEN=dWEN.
// - In ISERVE: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
// - Completion: ramstate==ACCESS while serving.
//   - Granted wait goes 0 combinationally in that same cycle.
//   - Read data is passed through: dload/iload = ramload.
//   - Next state IDLE. The other port's wait stays 1.
// - FREE/BUSY while serving: hold state; ram outputs stay stable; wait=1.
// - ERROR while serving: wait stays 1, next state IDLE. The request re-arbitrates
//   and is retried. No completion is signalled.
// - Abort: granted requester drops its request mid-serve.
//   - ram enables deassert that same cycle; next state IDLE; no completion.
// - Latency: request first seen in IDLE at cycle N.
//   - RAM is driven from cycle N+1.
//   - Earliest wait=0 is N+1.
//   - Back-to-back requests have at least one IDLE cycle between grants.
// - starve_cnt, updated at each completion:
//   - DSERVE completion while iREN=1 -> starve_cnt+1, saturating at STARVE_LIMIT.
//   - ISERVE completion, or any completion with iREN=0 -> starve_cnt=0.
// - Only one of iwait/dwait may be 0 in any cycle. ramREN&ramWEN is never 1.
// - Reset mid-transaction: state returns to IDLE next edge and the ram enables
//   drop; the caches must re-issue.
// TESTING
// 1. Reset with iREN=dREN=1 -> ramREN=ramWEN=0, iwait=dwait=1. First grant after
//    release is DSERVE.
// 2. iREN, iaddr=0x40, ramstate ACCESS on first serve cycle,
//    ramload=0x8C010004 -> iwait=0 at N+1, iload=0x8C010004, dwait=1.
// 3. dWEN, daddr=0x100, dstore=0xDEADBEEF, ramstate BUSY x3 then ACCESS
//    -> ramWEN=1 and ramaddr/ramstore stable 4 cycles; dwait=0 on cycle 4 only.
// 4. iREN held, dREN re-asserted every grant, STARVE_LIMIT=4 -> 4 dcache
//    completions, then ISERVE; starve_cnt returns to 0.
// 5. dREN served, ramstate ERROR once then ACCESS -> return to IDLE, regrant
//    DSERVE, dwait=0 only after ACCESS.
// 6. dREN dropped during BUSY -> ramREN=0 same cycle, state IDLE next edge,
//    dwait never 0.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//
// Purpose:
//   Sits between the icache/dcache request ports and a single-ported RAM bus.
//   Only one request is in flight at a time. The dcache wins arbitration by
//   default. A starvation counter forces an instruction fetch through after
//   STARVE_LIMIT consecutive dcache completions that happened while an
//   instruction fetch was waiting. The wait line of the granted port drops
//   in the same cycle the RAM reports ACCESS. On a read, the RAM data is
//   passed straight through to the granted port in that cycle.
//
// Parameters:
//   WORD_W        data width (iload/dload/dstore/ramstore/ramload)
//   ADDR_W        address width (iaddr/daddr/ramaddr)
//   STARVE_LIMIT  dcache completions tolerated while iREN waits
//
// Ports:
//   CLK          clock, rising edge
//   nRST         synchronous reset, active-low
//   iREN_i       icache read request
//   iaddr_i      icache address
//   iwait_o      0 = icache request completes this cycle
//   iload_o      instruction word to icache (valid when iwait_o=0)
//   dREN_i       dcache read request
//   dWEN_i       dcache write request (wins over dREN_i when both are high)
//   daddr_i      dcache address
//   dstore_i     dcache write data
//   dwait_o      0 = dcache request completes this cycle
//   dload_o      data word to dcache (valid when dwait_o=0)
//   ramREN_o     RAM read enable
//   ramWEN_o     RAM write enable
//   ramaddr_o    RAM address
//   ramstore_o   RAM write data
//   ramload_i    RAM read data
//   ramstate_i   RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
  parameter int WORD_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  // icache side
  input  logic              iREN_i,
  input  logic [ADDR_W-1:0] iaddr_i,
  output logic              iwait_o,
  output logic [WORD_W-1:0] iload_o,
  // dcache side
  input  logic              dREN_i,
  input  logic              dWEN_i,
  input  logic [ADDR_W-1:0] daddr_i,
  input  logic [WORD_W-1:0] dstore_i,
  output logic              dwait_o,
  output logic [WORD_W-1:0] dload_o,
  // RAM side
  output logic              ramREN_o,
  output logic              ramWEN_o,
  output logic [ADDR_W-1:0] ramaddr_o,
  output logic [WORD_W-1:0] ramstore_o,
  input  logic [WORD_W-1:0] ramload_i,
  input  logic [1:0]        ramstate_i
);

  // The counter must be able to hold STARVE_LIMIT itself, and it is always
  // at least one bit wide.
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISERVE = 2'd1,
    DSERVE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Request and status decode shared by the next-state and output logic.
  logic d_req;
  logic i_force;
  logic ram_access;
  logic ram_error;
  logic d_done;
  logic i_done;

  assign d_req      = dREN_i | dWEN_i;
  assign i_force    = iREN_i && (starve_cnt_q == LIMIT);
  assign ram_access = (ramstate_i == RAM_ACCESS);
  assign ram_error  = (ramstate_i == RAM_ERROR);

  // A completion requires the granted requester to still be asking. If the
  // request was dropped in the same cycle, this is an abort and not a
  // completion, even when the RAM reports ACCESS.
  assign d_done = (state_q == DSERVE) && d_req  && ram_access;
  assign i_done = (state_q == ISERVE) && iREN_i && ram_access;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;

    case (state_q)
      IDLE: begin
        if (d_req && !i_force) begin
          state_d = DSERVE;
        end else if (iREN_i) begin
          state_d = ISERVE;
        end
      end

      DSERVE: begin
        // Leave on abort, completion or error. FREE/BUSY holds the grant.
        // After an error the request re-arbitrates from IDLE.
        if (!d_req || ram_access || ram_error) begin
          state_d = IDLE;
        end
      end

      ISERVE: begin
        if (!iREN_i || ram_access || ram_error) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // The counter only moves on completions. Aborts and errors leave it alone.
    if (d_done) begin
      if (iREN_i) begin
        starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 1'b1;
      end else begin
        starve_cnt_d = '0;
      end
    end else if (i_done) begin
      starve_cnt_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    ramREN_o   = 1'b0;
    ramWEN_o   = 1'b0;
    ramaddr_o  = '0;
    ramstore_o = '0;
    iwait_o    = 1'b1;
    dwait_o    = 1'b1;
    iload_o    = '0;
    dload_o    = '0;

    case (state_q)
      DSERVE: begin
        ramaddr_o  = daddr_i;
        ramstore_o = dstore_i;
        // The enables follow the live request, so an abort drops them in the
        // same cycle. A simultaneous read+write is issued as a write only.
        ramWEN_o   = dWEN_i;
        ramREN_o   = dREN_i & ~dWEN_i;
        dwait_o    = ~d_done;
        if (d_done) begin
          dload_o = ramload_i;
        end
      end

      ISERVE: begin
        ramaddr_o = iaddr_i;
        ramREN_o  = iREN_i;
        iwait_o   = ~i_done;
        if (i_done) begin
          iload_o = ramload_i;
        end
      end

      default: begin
        // IDLE: the bus is quiet and both caches wait.
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
//
// Self-checking bench for cache_mem_arbiter. It runs three phases:
//   1. A table of per-cycle vectors. Each entry gives the inputs held for one
//      cycle and the outputs expected in that cycle.
//   2. A hand-written starvation sequence.
//   3. Random traffic checked against a transaction-level owner model.
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;

  localparam int LIMIT = 4;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef struct packed {
    logic        nrst;
    logic        iren;
    logic        dren;
    logic        dwen;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [1:0]  rs;
    logic [31:0] rload;
  } in_t;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic        iw;
    logic        dw;
    logic [31:0] il;
    logic [31:0] dl;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic        CLK;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int errors = 0;
  int checks = 0;

  cache_mem_arbiter #(
    .WORD_W      (32),
    .ADDR_W      (32),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .iREN_i    (iREN),
    .iaddr_i   (iaddr),
    .iwait_o   (iwait),
    .iload_o   (iload),
    .dREN_i    (dREN),
    .dWEN_i    (dWEN),
    .daddr_i   (daddr),
    .dstore_i  (dstore),
    .dwait_o   (dwait),
    .dload_o   (dload),
    .ramREN_o  (ramREN),
    .ramWEN_o  (ramWEN),
    .ramaddr_o (ramaddr),
    .ramstore_o(ramstore),
    .ramload_i (ramload),
    .ramstate_i(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- helpers ----------------
  function automatic in_t mk_i(logic nrst, logic ir, logic dr, logic dw,
                               logic [31:0] ia, logic [31:0] da, logic [31:0] ds,
                               logic [1:0] rs, logic [31:0] rl);
    in_t v;
    v.nrst = nrst; v.iren = ir; v.dren = dr; v.dwen = dw;
    v.iaddr = ia; v.daddr = da; v.dstore = ds; v.rs = rs; v.rload = rl;
    return v;
  endfunction

  function automatic out_t mk_o(logic ren, logic wen, logic [31:0] a, logic [31:0] s,
                                logic iw, logic dw, logic [31:0] il, logic [31:0] dl);
    out_t o;
    o.ren = ren; o.wen = wen; o.addr = a; o.store = s;
    o.iw = iw; o.dw = dw; o.il = il; o.dl = dl;
    return o;
  endfunction

  function automatic out_t idle_o();
    return mk_o(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0);
  endfunction

  task automatic drive(input in_t v);
    nRST = v.nrst; iREN = v.iren; dREN = v.dren; dWEN = v.dwen;
    iaddr = v.iaddr; daddr = v.daddr; dstore = v.dstore;
    ramstate = v.rs; ramload = v.rload;
  endtask

  function automatic out_t sample();
    return mk_o(ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload);
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ren=%b wen=%b addr=%h store=%h iw=%b dw=%b il=%h dl=%h | want ren=%b wen=%b addr=%h store=%h iw=%b dw=%b il=%h dl=%h",
               name, act.ren, act.wen, act.addr, act.store, act.iw, act.dw, act.il, act.dl,
               exp.ren, exp.wen, exp.addr, exp.store, exp.iw, exp.dw, exp.il, exp.dl);
    end
  endtask

  task automatic check_invariants(input string name);
    checks++;
    if ((!iwait && !dwait) || (ramREN && ramWEN)) begin
      errors++;
      $display("FAIL %s invariant: got iwait=%b dwait=%b ramREN=%b ramWEN=%b, want one wait high and not both enables",
               name, iwait, dwait, ramREN, ramWEN);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: who holds the bus (0 none, 1 icache, 2 dcache).
  // d_streak: dcache completions since the icache last got through while
  // it was waiting.
  int owner    = 0;
  int d_streak = 0;

  function automatic out_t model_out(input in_t v);
    out_t o;
    o = idle_o();
    if (owner == 2) begin
      o.addr  = v.daddr;
      o.store = v.dstore;
      if (v.dren || v.dwen) begin
        o.wen = v.dwen;
        o.ren = v.dren && !v.dwen;
        if (v.rs == RS_ACCESS) begin
          o.dw = 1'b0;
          o.dl = v.rload;
        end
      end
    end else if (owner == 1) begin
      o.addr = v.iaddr;
      o.ren  = v.iren;
      if (v.iren && v.rs == RS_ACCESS) begin
        o.iw = 1'b0;
        o.il = v.rload;
      end
    end
    return o;
  endfunction

  task automatic model_step(input in_t v);
    bit dreq;
    dreq = v.dren || v.dwen;
    if (!v.nrst) begin
      owner = 0;
      d_streak = 0;
    end else if (owner == 0) begin
      if (dreq && !(v.iren && d_streak == LIMIT)) owner = 2;
      else if (v.iren) owner = 1;
    end else if (owner == 2) begin
      if (dreq && v.rs == RS_ACCESS) d_streak = v.iren ? ((d_streak + 1 > LIMIT) ? LIMIT : d_streak + 1) : 0;
      if (!dreq || v.rs == RS_ACCESS || v.rs == RS_ERROR) owner = 0;
    end else begin
      if (v.iren && v.rs == RS_ACCESS) d_streak = 0;
      if (!v.iren || v.rs == RS_ACCESS || v.rs == RS_ERROR) owner = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[22];

  initial begin
    string  exp_seq;
    byte    got_q[$];
    in_t    v;
    int     cyc;

    // Directed per-cycle vectors, starting from the IDLE state.
    vecs[0]  = '{mk_i(0,1,1,0,32'h40,32'h200,32'h0,RS_ACCESS,32'h0), idle_o()};
    vecs[1]  = '{mk_i(1,1,1,0,32'h40,32'h200,32'h0,RS_FREE,32'h0), idle_o()};
    vecs[2]  = '{mk_i(1,1,1,0,32'h40,32'h200,32'h0,RS_ACCESS,32'h11112222),
                 mk_o(1,0,32'h200,32'h0,1,0,32'h0,32'h11112222)};
    vecs[3]  = '{mk_i(1,1,0,0,32'h40,32'h0,32'h0,RS_FREE,32'h0), idle_o()};
    vecs[4]  = '{mk_i(1,1,0,0,32'h40,32'h0,32'h0,RS_ACCESS,32'h8C010004),
                 mk_o(1,0,32'h40,32'h0,0,1,32'h8C010004,32'h0)};
    vecs[5]  = '{mk_i(1,0,0,1,32'h0,32'h100,32'hDEADBEEF,RS_FREE,32'h0), idle_o()};
    vecs[6]  = '{mk_i(1,0,0,1,32'h0,32'h100,32'hDEADBEEF,RS_BUSY,32'h0),
                 mk_o(0,1,32'h100,32'hDEADBEEF,1,1,32'h0,32'h0)};
    vecs[7]  = vecs[6];
    vecs[8]  = vecs[6];
    vecs[9]  = '{mk_i(1,0,0,1,32'h0,32'h100,32'hDEADBEEF,RS_ACCESS,32'h0),
                 mk_o(0,1,32'h100,32'hDEADBEEF,1,0,32'h0,32'h0)};
    vecs[10] = '{mk_i(1,0,1,0,32'h0,32'h300,32'h0,RS_FREE,32'h0), idle_o()};
    vecs[11] = '{mk_i(1,0,1,0,32'h0,32'h300,32'h0,RS_BUSY,32'h0),
                 mk_o(1,0,32'h300,32'h0,1,1,32'h0,32'h0)};
    vecs[12] = '{mk_i(1,0,0,0,32'h0,32'h300,32'h0,RS_BUSY,32'h0),
                 mk_o(0,0,32'h300,32'h0,1,1,32'h0,32'h0)};
    vecs[13] = '{mk_i(1,0,0,0,32'h0,32'h300,32'h0,RS_ACCESS,32'h0), idle_o()};
    vecs[14] = '{mk_i(1,0,1,0,32'h0,32'h500,32'h0,RS_FREE,32'h0), idle_o()};
    vecs[15] = '{mk_i(1,0,1,0,32'h0,32'h500,32'h0,RS_ERROR,32'h0),
                 mk_o(1,0,32'h500,32'h0,1,1,32'h0,32'h0)};
    vecs[16] = '{mk_i(1,0,1,0,32'h0,32'h500,32'h0,RS_FREE,32'h0), idle_o()};
    vecs[17] = '{mk_i(1,0,1,0,32'h0,32'h500,32'h0,RS_ACCESS,32'hCAFEF00D),
                 mk_o(1,0,32'h500,32'h0,1,0,32'h0,32'hCAFEF00D)};
    vecs[18] = '{mk_i(1,0,1,1,32'h0,32'h600,32'h12345678,RS_FREE,32'h0), idle_o()};
    vecs[19] = '{mk_i(1,0,1,1,32'h0,32'h600,32'h12345678,RS_BUSY,32'h0),
                 mk_o(0,1,32'h600,32'h12345678,1,1,32'h0,32'h0)};
    vecs[20] = '{mk_i(0,0,1,1,32'h0,32'h600,32'h12345678,RS_BUSY,32'h0),
                 mk_o(0,1,32'h600,32'h12345678,1,1,32'h0,32'h0)};
    vecs[21] = '{mk_i(1,0,0,0,32'h0,32'h0,32'h0,RS_ACCESS,32'h0), idle_o()};

    drive(mk_i(0,0,0,0,0,0,0,RS_FREE,0));
    repeat (2) @(posedge CLK);
    #1;

    for (int k = 0; k < 22; k++) begin
      drive(vecs[k].i);
      @(negedge CLK);
      check($sformatf("vec%0d", k), vecs[k].o);
      @(posedge CLK);
      #1;
    end

    // Starvation: both caches keep asking and the RAM completes instantly.
    drive(mk_i(0,0,0,0,0,0,0,RS_FREE,0));
    @(posedge CLK);
    #1;
    drive(mk_i(1,1,1,0,32'h44,32'h88,32'h0,RS_ACCESS,32'h5));
    exp_seq = "ddddiddddi";
    cyc = 0;
    while (cyc < 60 && got_q.size() < 10) begin
      @(negedge CLK);
      if (!dwait) got_q.push_back("d");
      if (!iwait) got_q.push_back("i");
      @(posedge CLK);
      #1;
      cyc++;
    end
    if (got_q.size() < 10) begin
      checks++;
      errors++;
      $display("FAIL starve_timeout: got %0d completions, want 10 within 60 cycles", got_q.size());
    end
    for (int k = 0; k < 10 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k] != exp_seq[k]) begin
        errors++;
        $display("FAIL starve_order%0d: got %s completion, want %s", k,
                 string'(got_q[k]), string'(exp_seq[k]));
      end
    end

    // Random traffic against the owner model, starting from reset.
    drive(mk_i(0,0,0,0,0,0,0,RS_FREE,0));
    @(posedge CLK);
    #1;
    owner = 0;
    d_streak = 0;
    for (int n = 0; n < 3000; n++) begin
      v.nrst   = ($urandom_range(0, 63) != 0);
      v.iren   = ($urandom_range(0, 3) != 0);
      v.dren   = ($urandom_range(0, 2) == 0);
      v.dwen   = ($urandom_range(0, 3) == 0);
      v.iaddr  = $urandom_range(0, 255) << 2;
      v.daddr  = $urandom_range(0, 255) << 2;
      v.dstore = $urandom;
      v.rs     = 2'($urandom_range(0, 3));
      v.rload  = $urandom;
      drive(v);
      @(negedge CLK);
      check($sformatf("rand%0d", n), model_out(v));
      check_invariants($sformatf("rand%0d", n));
      @(posedge CLK);
      model_step(v);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
